// File: rtl/poly1305_pkg.sv
// Shared definitions for the Poly1305 datapath: modulus, r clamp mask,
// datapath widths, the block-multiplier state encoding and the clamp helper.
package poly1305_pkg;

    localparam int ACC_W  = 130;   // accumulator h
    localparam int SUM_W  = 131;   // h + padded block, no truncation
    localparam int PROD_W = 258;   // product handed to the reducer
    localparam int KEY_W  = 128;   // r
    localparam int BLK_W  = 128;   // raw message block
    localparam int PAD_W  = 129;   // padded block m

    localparam logic [ACC_W-1:0] POLY1305_P   = 130'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
    localparam logic [KEY_W-1:0] R_CLAMP_MASK = 128'h0fff_fffc_0fff_fffc_0fff_fffc_0fff_ffff;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_MUL  = 3'd2,
        ST_REQ  = 3'd3,
        ST_WAIT = 3'd4
    } state_e;

    // Clear the bits of r that Poly1305 requires to be zero.
    function automatic logic [KEY_W-1:0] clamp_r(input logic [KEY_W-1:0] raw);
        return raw & R_CLAMP_MASK;
    endfunction

endpackage

// File: rtl/poly1305_pad.sv
// Combinational Poly1305 block padding.
// Ports:
//   blk_data in  128  block as little-endian integer
//   blk_len  in  5    byte count (16..31 = full block, 0 = empty block)
//   m        out 129  padded block: low blk_len bytes plus a 1 just above them
module poly1305_pad
    import poly1305_pkg::*;
(
    input  logic [BLK_W-1:0] blk_data,
    input  logic [4:0]       blk_len,
    output logic [PAD_W-1:0] m
);

    logic [6:0]       bit_cnt_s;
    logic [PAD_W-1:0] pad_bit_s;
    logic [PAD_W-1:0] data_ext_s;

    // Select full-block, empty-block or masked partial-block padding.
    always_comb begin
        bit_cnt_s  = {blk_len[3:0], 3'b000};
        pad_bit_s  = 129'd1 << bit_cnt_s;
        data_ext_s = {1'b0, blk_data};
        if (blk_len[4]) begin
            m = {1'b1, blk_data};
        end else if (blk_len[3:0] == 4'd0) begin
            m = 129'd1;
        end else begin
            // pad_bit - 1 is the mask of the low n bytes
            m = (data_ext_s & (pad_bit_s - 129'd1)) | pad_bit_s;
        end
    end

endmodule

// File: rtl/poly1305_block_mul.sv
// Poly1305 accumulate-and-multiply stage: h <- reduce((h + m) * r).
// Forms the 258-bit product with a STEP-bits-per-cycle shift-add multiplier,
// hands it to an external mod (2^130-5) reducer and writes the result to h.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   key_load, key_r          load clamped r (IDLE only)
//   acc_clear                zero h (IDLE only; applied before key_load)
//   blk_valid/blk_ready      block handshake; blk_data/blk_len block payload
//   red_start/red_value      one-cycle reducer request with the product
//   red_busy/red_done/red_result  reducer status and result
//   acc_out                  current h
//   busy, done               not-IDLE flag; one-cycle pulse when h updates
module poly1305_block_mul
    import poly1305_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               key_load,
    input  logic [KEY_W-1:0]   key_r,
    input  logic               acc_clear,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLK_W-1:0]   blk_data,
    input  logic [4:0]         blk_len,
    output logic               red_start,
    output logic [PROD_W-1:0]  red_value,
    input  logic               red_busy,
    input  logic               red_done,
    input  logic [ACC_W-1:0]   red_result,
    output logic [ACC_W-1:0]   acc_out,
    output logic               busy,
    output logic               done
);

    localparam int         NDIG     = KEY_W / STEP;
    localparam logic [6:0] LAST_DIG = 7'(NDIG - 1);

    state_e              state_r;
    logic [KEY_W-1:0]    r_r;
    logic [KEY_W-1:0]    rsh_r;      // r shifted left as digits are consumed
    logic [ACC_W-1:0]    h_r;
    logic [SUM_W-1:0]    s_r;
    logic [PROD_W-1:0]   p_r;
    logic [6:0]          cnt_r;
    logic [BLK_W-1:0]    data_r;
    logic [4:0]          len_r;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;
    logic [PAD_W-1:0]    m_s;
    logic [PROD_W-1:0]   prod_s;

    poly1305_pad u_pad (
        .blk_data (data_r),
        .blk_len  (len_r),
        .m        (m_s)
    );

    // Partial product of s with the current most-significant r digit.
    assign prod_s = PROD_W'(s_r) * PROD_W'(rsh_r[KEY_W-1 -: STEP]);

    // Commands take the IDLE cycle they appear in, so a block waits one cycle.
    assign blk_ready = ready_r & ~key_load & ~acc_clear;
    assign red_start = (state_r == ST_REQ) & ~red_busy;
    assign red_value = p_r;
    assign acc_out   = h_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Block FSM with adder, shift-add multiplier and h write-back.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            r_r     <= {KEY_W{1'b0}};
            rsh_r   <= {KEY_W{1'b0}};
            h_r     <= {ACC_W{1'b0}};
            s_r     <= {SUM_W{1'b0}};
            p_r     <= {PROD_W{1'b0}};
            cnt_r   <= 7'd0;
            data_r  <= {BLK_W{1'b0}};
            len_r   <= 5'd0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (acc_clear) begin
                        h_r <= {ACC_W{1'b0}};
                    end
                    if (key_load) begin
                        r_r <= clamp_r(key_r);
                    end
                    if (blk_valid && blk_ready) begin
                        data_r  <= blk_data;
                        len_r   <= blk_len;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_ADD;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_ADD: begin
                    s_r     <= {1'b0, h_r} + {2'b00, m_s};
                    p_r     <= {PROD_W{1'b0}};
                    rsh_r   <= r_r;
                    cnt_r   <= 7'd0;
                    state_r <= ST_MUL;
                end
                ST_MUL: begin
                    p_r   <= (p_r << STEP) + prod_s;
                    rsh_r <= rsh_r << STEP;
                    cnt_r <= cnt_r + 7'd1;
                    if (cnt_r == LAST_DIG) begin
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!red_busy) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (red_done) begin
                        h_r     <= red_result;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly1305_block_mul.sv
// Scoreboard bench for poly1305_block_mul: stimulus pushes expected reducer
// requests and accumulator values, a monitor pops and compares them.
module tb_poly1305_block_mul;
    import poly1305_pkg::*;

    localparam int STEP = 1;
    localparam int NDIG = 128 / STEP;

    logic         clk;
    logic         reset_n;
    logic         key_load;
    logic [127:0] key_r;
    logic         acc_clear;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic [4:0]   blk_len;
    logic         red_start;
    logic [257:0] red_value;
    logic         red_busy;
    logic         red_done;
    logic [129:0] red_result;
    logic [129:0] acc_out;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    logic [257:0] exp_red_q[$];
    logic [129:0] exp_acc_q[$];
    logic [129:0] h_m;
    logic [127:0] r_m;

    poly1305_block_mul #(.STEP(STEP)) dut (
        .clk(clk), .reset_n(reset_n), .key_load(key_load), .key_r(key_r),
        .acc_clear(acc_clear), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .blk_len(blk_len), .red_start(red_start),
        .red_value(red_value), .red_busy(red_busy), .red_done(red_done),
        .red_result(red_result), .acc_out(acc_out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [257:0] got, input logic [257:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Padding computed arithmetically from the byte count.
    function automatic logic [257:0] pad_ref(input logic [127:0] d, input int n);
        logic [257:0] base;
        if (n >= 16) return {130'd0, d} + (258'd1 << 128);
        if (n == 0) return 258'd1;
        base = 258'd1 << (8 * n);
        return ({130'd0, d} % base) + base;
    endfunction

    // Monitor: every reducer request and every done pulse consumes one expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (red_start) begin
                if (exp_red_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL red_start_unexpected: got %h required none", red_value);
                end else begin
                    chk("red_value", red_value, exp_red_q.pop_front());
                end
            end
            if (done) begin
                if (exp_acc_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL done_unexpected: got %h required none", acc_out);
                end else begin
                    chk("acc_out", {128'd0, acc_out}, {128'd0, exp_acc_q.pop_front()});
                end
            end
        end
    end

    task automatic cmd(input bit clr, input bit ld, input logic [127:0] k);
        @(posedge clk); #1;
        acc_clear = clr; key_load = ld; key_r = k;
        @(negedge clk);
        chk("ready_low_on_cmd", blk_ready, 0);
        @(posedge clk); #1;
        acc_clear = 1'b0; key_load = 1'b0;
        if (clr) h_m = 130'd0;
        if (ld) r_m = k & R_CLAMP_MASK;
        if (clr) begin
            @(negedge clk);
            chk("acc_clear", acc_out, 0);
        end
    endtask

    // Feed one block, act as reducer, check handshake timing.
    task automatic run_block(input logic [127:0] d, input int n, input bit use_key,
                             input logic [127:0] k, input int hold, input int lat,
                             input bit keep_valid, output logic [257:0] last_red);
        logic [257:0] s_x, p_x, pmod, cap;
        int cyc, bad, bad2, tries;
        bit got;
        pmod = {128'd0, POLY1305_P};
        @(posedge clk); #1;
        blk_data = d; blk_len = n[4:0]; blk_valid = 1'b1; red_busy = (hold > 0);
        if (use_key) begin
            key_load = 1'b1; key_r = k;
            @(negedge clk);
            chk("ready_low_with_key", blk_ready, 0);
            @(posedge clk); #1;
            key_load = 1'b0;
            r_m = k & R_CLAMP_MASK;
        end
        got = 1'b0; tries = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (blk_ready) got = 1'b1; else tries++;
        end
        chk("block_accepted", got, 1);
        if (use_key) chk("accept_after_key", tries, 0);
        s_x = {128'd0, h_m} + pad_ref(d, n);
        p_x = s_x * {130'd0, r_m};
        exp_red_q.push_back(p_x);
        h_m = 130'(p_x % pmod);
        exp_acc_q.push_back(h_m);
        @(posedge clk); #1;
        if (!keep_valid) blk_valid = 1'b0;
        cyc = 1; bad = 0; got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (blk_ready) bad++;
            if (red_start) got = 1'b1;
            else begin
                @(posedge clk); #1;
                if (cyc >= 1 + NDIG + hold) red_busy = 1'b0;
                cyc++;
            end
        end
        chk("red_start_seen", got, 1);
        chk("red_start_cycle", cyc, 2 + NDIG + hold);
        cap = red_value;
        last_red = cap;
        @(posedge clk); #1;
        bad2 = 0;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (red_start || done) bad2++;
            if (blk_ready) bad++;
            @(posedge clk); #1;
        end
        red_done = 1'b1; red_result = 130'(cap % pmod);
        @(negedge clk);
        if (red_start || done) bad2++;
        if (blk_ready) bad++;
        @(posedge clk); #1;
        red_done = 1'b0; red_result = {$urandom, $urandom, $urandom, $urandom, 2'b10};
        @(negedge clk);
        chk("done_pulse", done, 1);
        if (blk_ready) bad++;
        blk_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_single", done, 0);
        chk("ready_after_done", blk_ready, 1);
        chk("busy_after_done", busy, 0);
        chk("ready_low_while_busy", bad, 0);
        chk("wait_quiet", bad2, 0);
    endtask

    initial begin
        logic [257:0] red;
        logic [257:0] c;
        int bad;
        reset_n = 1'b0; key_load = 1'b0; key_r = 128'd0; acc_clear = 1'b0;
        blk_valid = 1'b0; blk_data = 128'd0; blk_len = 5'd0;
        red_busy = 1'b0; red_done = 1'b0; red_result = 130'd0;
        h_m = 130'd0; r_m = 128'd0;

        @(posedge clk);
        @(negedge clk);
        chk("rst_blk_ready", blk_ready, 0);
        chk("rst_red_start", red_start, 0);
        chk("rst_red_value", red_value, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", blk_ready, 1);

        // Unit r, full zero block
        cmd(1'b1, 1'b1, 128'd1);
        run_block(128'd0, 16, 1'b0, 128'd0, 0, 2, 1'b0, red);
        c = 258'd1 << 128;
        chk("t1_red", red, c);
        chk("t1_acc", {128'd0, acc_out}, c);

        // Product wraps past the modulus
        cmd(1'b0, 1'b1, 128'd2);
        run_block(128'd0, 16, 1'b0, 128'd0, 0, 0, 1'b0, red);
        c = 258'd1 << 130;
        chk("t2_red", red, c);
        chk("t2_acc", acc_out, 5);

        // RFC 8439 first block; key load together with blk_valid, valid held
        cmd(1'b1, 1'b0, 128'd0);
        run_block(128'h6f4620636968706172676f7470797243, 16, 1'b1,
                  128'h0806d5400e52447c036d555408bed685, 0, 3, 1'b1, red);
        chk("rfc_acc", acc_out, 130'h2c88c77849d64ae9147ddeb88e69c83fc);

        // One-byte block with the reducer busy for 20 cycles at REQ
        cmd(1'b1, 1'b1, 128'd1);
        run_block({4{32'hffffffff}}, 1, 1'b0, 128'd0, 20, 1, 1'b0, red);
        chk("partial_red", red, 258'h1ff);

        // Length boundaries
        run_block({4{32'hffffffff}}, 15, 1'b0, 128'd0, 0, 1, 1'b0, red);
        run_block({4{32'h5a5aa5a5}}, 0, 1'b1, {4{32'h12345678}}, 0, 0, 1'b0, red);
        run_block({4{32'h89abcdef}}, 31, 1'b0, 128'd0, 1, 2, 1'b0, red);

        // Randomized blocks
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 4) == 0) cmd(1'b1, 1'b0, 128'd0);
            run_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 31),
                      ($urandom_range(0, 2) == 0), {$urandom, $urandom, $urandom, $urandom},
                      $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 1), red);
        end

        // Reset in the middle of the multiply
        @(posedge clk); #1;
        blk_data = {$urandom, $urandom, $urandom, $urandom}; blk_len = 5'd16; blk_valid = 1'b1;
        @(negedge clk);
        chk("mid_accept_ready", blk_ready, 1);
        @(posedge clk); #1;
        blk_valid = 1'b0;
        repeat (48) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_blk_ready", blk_ready, 0);
        chk("mid_rst_red_start", red_start, 0);
        chk("mid_rst_red_value", red_value, 0);
        chk("mid_rst_acc_out", acc_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        h_m = 130'd0; r_m = 128'd0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (red_start || busy) bad++;
        end
        chk("no_start_after_reset", bad, 0);
        @(posedge clk); #1;
        red_done = 1'b1; red_result = 130'h1_2345;
        @(posedge clk); #1;
        red_done = 1'b0;
        @(negedge clk);
        chk("stray_done_acc", acc_out, 0);
        chk("stray_done_pulse", done, 0);

        // r was cleared by reset, so the product is zero
        run_block({$urandom, $urandom, $urandom, $urandom}, 16, 1'b0, 128'd0, 0, 1, 1'b0, red);
        chk("post_reset_red", red, 0);

        chk("scoreboard_drained", exp_red_q.size() + exp_acc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poly1305_block_mul.md
# poly1305_block_mul

Accumulate-and-multiply stage of the Poly1305 MAC datapath. It holds the clamped key half r and the 130-bit accumulator h. For each message block it forms (h + padded block) * r as a 258-bit product, hands the product to the downstream modulo-(2^130-5) reducer, and writes the reduced result back into h. It sits between the message-block feeder and the reducer.

## Interface
- STEP, default 1: bits of r consumed per multiply cycle. Legal values are 1, 2, 4, 8.
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- key_load  in  1  load r from key_r (honoured in IDLE only)
- key_r  in  128  raw r, little-endian integer; clamped on load
- acc_clear  in  1  set h to 0 (honoured in IDLE only)
- blk_valid  in  1  block offered
- blk_ready  out  1  block may be accepted this cycle
- blk_data  in  128  block as little-endian integer; bytes at or above blk_len are ignored
- blk_len  in  5  byte count
- red_start  out  1  one-cycle request to the reducer
- red_value  out  258  product presented to the reducer
- red_busy  in  1  reducer occupied
- red_done  in  1  reducer result valid (one-cycle pulse)
- red_result  in  130  reduced value from the reducer
- acc_out  out  130  current h
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when h has been updated

## Operation
- Clamp applied on load: r = key_r & 0x0ffffffc0ffffffc0ffffffc0fffffff.
- Padding rule for m, given n = blk_len:
  - n in 16..31: m = blk_data + 2^128.
  - n in 1..15: m = (blk_data masked to the low n bytes) + 2^(8n).
  - n = 0: m = 1.
- Width rules:
  - The sum s = h + m is 131 bits and is formed without truncation.
  - The product p = s * r is less than 2^255 and is zero-extended to 258 bits.
- Command priority in IDLE:
  - acc_clear, then key_load. Both may act in the same cycle.
  - blk_ready is low in any cycle where either command is asserted.
  - key_load and acc_clear are ignored outside IDLE.
- State machine:
  - IDLE: blk_ready = 1. On blk_valid && blk_ready, capture blk_data and blk_len, then go to ADD.
  - ADD (1 cycle): s <= h + m. Clear the product register. Go to MUL.
  - MUL (128/STEP cycles): take r digits MSB-first, p <= (p << STEP) + s * digit. After the last digit, go to REQ.
  - REQ: hold red_value = p. When red_busy = 0, assert red_start for exactly one cycle and go to WAIT. While red_busy = 1, stay in REQ with red_start low.
  - WAIT: on red_done, h <= red_result, pulse done, go to IDLE.
- red_done outside WAIT is ignored.
- red_value is held stable from REQ until the transition out of WAIT.
- A new block arriving while busy is back-pressured (blk_ready = 0). It is never dropped.

## Timing
- Reset values: blk_ready 0 in the reset cycle, then 1 in IDLE. red_start 0. red_value 0. acc_out 0. busy 0. done 0. Internal r, h, s and p are all 0.
- Cycle numbering, with acceptance at cycle 0:
  - ADD at cycle 1.
  - MUL at cycles 2 .. 1+128/STEP.
  - Earliest red_start at cycle 2+128/STEP (cycle 130 for STEP=1).
- done is asserted the cycle after red_done is seen in WAIT. acc_out updates in the same cycle as done.
- blk_ready rises in the cycle after done. Back-to-back blocks are therefore 1 + 1 + 128/STEP + 1 + (reducer latency) + 1 cycles apart at minimum.
- reset_n low in any state returns the block to IDLE on the next edge with all values at reset. A reducer operation already in flight is abandoned, and its later red_done is ignored.

## Structure
- Shared package poly1305_pkg holds:
  - POLY1305_P = 2^130-5
  - R_CLAMP_MASK
  - the widths ACC_W=130, SUM_W=131, PROD_W=258
  - the state enum
- The reducer uses ACC_W and PROD_W from the same package.
- One sub-module, poly1305_pad: combinational blk_data/blk_len to 129-bit m.
- The FSM, adder and shift-add multiplier live in the top module.

## Test plan
- Unit r, full block: key_r=1, acc_clear, blk_data=0, blk_len=16.
  - Required: red_value = 2^128.
  - With the reducer model, acc_out = 2^128 and done pulses once.
- Overflow into the modulus: key_r=2, h=2^128 (from the previous test), blk_data=0, blk_len=16.
  - Required: red_value = 2^130; acc_out = 5 after reduction.
- RFC 8439 §2.5.2 first block: key_r = 0x0806d5400e52447c036d555408bed685, h=0, blk_data = 0x6f4620636968706172676f7470797243, blk_len=16.
  - Required: acc_out = 0x2c88c77849d64ae9147ddeb88e69c83fc.
- Partial block: blk_len=1, blk_data=0xFFFF…FF, r=1, h=0.
  - Required: red_value = 0x1FF (masked byte plus pad bit).
- Back-pressure and priority:
  - Hold red_busy=1 for 20 cycles at REQ. Required: red_start stays low, then pulses once after red_busy falls.
  - Drive blk_valid throughout. Required: blk_ready stays 0 until after done.
  - Drive key_load and blk_valid together in IDLE. Required: the key loads first and the block is accepted on the next cycle.
- Reset mid-MUL: assert reset_n=0 at cycle 50.
  - Required: all outputs 0, no red_start.
  - A stray red_done after reset is ignored, and acc_out stays 0.
